// File: rtl/focus_phase_scheduler.sv
// Focus/phase scheduler: one START streams TRANS_NUM ROM positions into the phase calculator
// and writes the returned phases, in order, into the phase RAM. Optional macro: FOCUS_SCHED_TIMEOUT_EN.
module focus_phase_scheduler #(
  parameter int TRANS_NUM      = 249,
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic signed [17:0]       focus_x_i,
  input  logic signed [17:0]       focus_y_i,
  input  logic signed [17:0]       focus_z_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [ADDR_W-1:0]        pos_addr_o,
  input  logic signed [17:0]       pos_x_i,
  input  logic signed [17:0]       pos_y_i,
  input  logic signed [17:0]       pos_z_i,
  output logic                     calc_dvalid_o,
  output logic signed [17:0]       calc_focus_x_o,
  output logic signed [17:0]       calc_focus_y_o,
  output logic signed [17:0]       calc_focus_z_o,
  output logic signed [17:0]       calc_trans_x_o,
  output logic signed [17:0]       calc_trans_y_o,
  output logic signed [17:0]       calc_trans_z_o,
  input  logic [7:0]               calc_phase_i,
  input  logic                     calc_done_i,
  output logic                     phase_we_o,
  output logic [ADDR_W-1:0]        phase_addr_o,
  output logic [7:0]               phase_data_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  // one extra bit so TRANS_NUM == 2**ADDR_W does not wrap
  localparam logic [ADDR_W:0] TN    = (ADDR_W+1)'(TRANS_NUM);
  localparam logic [ADDR_W:0] TN_M1 = (ADDR_W+1)'(TRANS_NUM - 1);

  logic [1:0]              state_q, state_d;
  logic [ADDR_W-1:0]       rd_cnt_q, rd_cnt_d;
  logic [ADDR_W:0]         wr_cnt_q, wr_cnt_d;
  logic signed [17:0]      fx_q, fy_q, fz_q;
  logic                    dvalid_q;
  logic                    we_q;
  logic [ADDR_W-1:0]       waddr_q;
  logic [7:0]              wdata_q;
  logic                    accept, issue_last, capture, tmo_hit;

  assign accept     = (state_q == S_IDLE) && start_i;
  assign issue_last = (state_q == S_ISSUE) && ({1'b0, rd_cnt_q} == TN_M1);
  assign capture    = calc_done_i && (wr_cnt_q != TN) &&
                      ((state_q == S_ISSUE) || (state_q == S_DRAIN));

  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    case (state_q)
      S_IDLE: if (start_i) begin
        state_d  = S_ISSUE;
        rd_cnt_d = '0;
        wr_cnt_d = '0;
      end
      S_ISSUE: begin
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (issue_last) state_d = S_DRAIN;
      end
      S_DRAIN:  if ((wr_cnt_q == TN) || tmo_hit) state_d = S_FINISH;
      default:  state_d = S_IDLE;
    endcase
    if (capture) wr_cnt_d = wr_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      fx_q     <= '0;
      fy_q     <= '0;
      fz_q     <= '0;
      dvalid_q <= 1'b0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      dvalid_q <= (state_q == S_ISSUE);
      we_q     <= capture;
      if (accept) begin
        fx_q <= focus_x_i;
        fy_q <= focus_y_i;
        fz_q <= focus_z_i;
      end
      if (capture) begin
        waddr_q <= wr_cnt_q[ADDR_W-1:0];
        wdata_q <= calc_phase_i;
      end
    end
  end

`ifdef FOCUS_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q;

  // counts idle DRAIN cycles since the last result; DONE/ERR show up when it reads TIMEOUT_CYCLES
  always_comb begin
    tmo_d = '0;
    if ((state_q == S_DRAIN) && !calc_done_i) tmo_d = tmo_q + 1'b1;
  end
  assign tmo_hit = (state_q == S_DRAIN) && (tmo_d == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      if (accept)       err_q <= 1'b0;
      else if (tmo_hit) err_q <= 1'b1;
    end
  end
  assign err_o = err_q;
`else
  assign tmo_hit = 1'b0;
  assign err_o   = 1'b0;
`endif

  assign busy_o         = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done_o         = (state_q == S_FINISH);
  assign pos_addr_o     = (state_q == S_ISSUE) ? rd_cnt_q : '0;
  assign calc_dvalid_o  = dvalid_q;
  assign calc_focus_x_o = fx_q;
  assign calc_focus_y_o = fy_q;
  assign calc_focus_z_o = fz_q;
  // ROM data already lags POS_ADDR by one cycle, so it lines up with the registered valid
  assign calc_trans_x_o = dvalid_q ? pos_x_i : '0;
  assign calc_trans_y_o = dvalid_q ? pos_y_i : '0;
  assign calc_trans_z_o = dvalid_q ? pos_z_i : '0;
  assign phase_we_o     = we_q;
  assign phase_addr_o   = waddr_q;
  assign phase_data_o   = wdata_q;

endmodule

// File: tb/tb_focus_phase_scheduler.sv
// Scoreboard bench for focus_phase_scheduler: stimulus pushes expected DVALID beats, RAM writes
// and DONE pulses; a negedge monitor pops and compares them as the DUT presents them.
module tb_focus_phase_scheduler;
  localparam int TN = 4, AW = 8, TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic start = 1'b0;
  logic signed [17:0] fx = '0, fy = '0, fz = '0;
  logic busy, done, err, dvalid, phase_we, calc_done;
  logic [AW-1:0] pos_addr, phase_addr;
  logic signed [17:0] pos_x, pos_y, pos_z;
  logic signed [17:0] cfx, cfy, cfz, ctx, cty, ctz;
  logic [7:0] calc_phase, phase_data;

  focus_phase_scheduler #(.TRANS_NUM(TN), .ADDR_W(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .focus_x_i(fx), .focus_y_i(fy), .focus_z_i(fz),
    .busy_o(busy), .done_o(done), .err_o(err),
    .pos_addr_o(pos_addr), .pos_x_i(pos_x), .pos_y_i(pos_y), .pos_z_i(pos_z),
    .calc_dvalid_o(dvalid),
    .calc_focus_x_o(cfx), .calc_focus_y_o(cfy), .calc_focus_z_o(cfz),
    .calc_trans_x_o(ctx), .calc_trans_y_o(cty), .calc_trans_z_o(ctz),
    .calc_phase_i(calc_phase), .calc_done_i(calc_done),
    .phase_we_o(phase_we), .phase_addr_o(phase_addr), .phase_data_o(phase_data)
  );

  // position ROM, 1-cycle read latency, pos = addr*10
  logic [AW-1:0] rom_addr_q = '0;
  always @(posedge clk) rom_addr_q <= pos_addr;
  assign pos_x = 18'(int'(rom_addr_q) * 10);
  assign pos_y = 18'(-int'(rom_addr_q) * 10);
  assign pos_z = 18'(int'(rom_addr_q) * 10 + 1);

  // calculator model: phase = index + 5 after 26 cycles; only the first model_lim beats answer
  logic        model_en  = 1'b1;
  int          model_lim = TN;
  int          model_cnt = 0;
  logic [25:0] pv = '0;
  logic [7:0]  pdat [26];
  logic        inj_v = 1'b0;
  logic [7:0]  inj_d = '0;
  always @(posedge clk) begin
    pv[0]   <= dvalid && model_en && (model_cnt < model_lim);
    pdat[0] <= 8'(int'(ctx) / 10 + 5);
    for (int k = 1; k < 26; k++) begin
      pv[k]   <= pv[k-1];
      pdat[k] <= pdat[k-1];
    end
    if (!busy) model_cnt <= 0;
    else if (dvalid) model_cnt <= model_cnt + 1;
  end
  assign calc_done  = pv[25] | inj_v;
  assign calc_phase = pv[25] ? pdat[25] : inj_d;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0, nerr = 0;
  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {int cyc; int x;} dv_t;
  typedef struct {int a; int d;}   wr_t;
  typedef struct {int err; int cyc;} dn_t;
  dv_t exp_dv[$];
  wr_t exp_wr[$];
  dn_t exp_dn[$];
  int efx, efy, efz;

  // monitor
  always @(negedge clk) begin
    dv_t v; wr_t w; dn_t d;
    if (!rst) begin
      if (dvalid) begin
        if (exp_dv.size() == 0) chk("unexpected_dvalid", int'(dvalid), 0);
        else begin
          v = exp_dv.pop_front();
          chk("dvalid_cycle", cyc, v.cyc);
          chk("trans_x", int'(ctx), v.x);
          chk("focus_x", int'(cfx), efx);
          chk("focus_y", int'(cfy), efy);
          chk("focus_z", int'(cfz), efz);
        end
      end
      if (phase_we) begin
        if (exp_wr.size() == 0) chk("unexpected_write", int'(phase_we), 0);
        else begin
          w = exp_wr.pop_front();
          chk("phase_addr", int'(phase_addr), w.a);
          chk("phase_data", int'(phase_data), w.d);
        end
      end
      if (done) begin
        if (exp_dn.size() == 0) chk("unexpected_done", int'(done), 0);
        else begin
          d = exp_dn.pop_front();
          chk("done_err", int'(err), d.err);
          if (d.cyc >= 0) chk("done_cycle", cyc, d.cyc);
          chk("writes_left_at_done", exp_wr.size(), 0);
          chk("busy_at_done", int'(busy), 0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic go(input int x, input int y, input int z);
    start = 1'b1; fx = 18'(x); fy = 18'(y); fz = 18'(z);
    tick();
    start = 1'b0;
  endtask

  task automatic push_op(input int s, input int x, input int y, input int z,
                         input int nwr, input int base, input int e, input int dcyc);
    efx = x; efy = y; efz = z;
    for (int i = 0; i < TN; i++) exp_dv.push_back('{s + 2 + i, i * 10});
    for (int i = 0; i < nwr; i++) exp_wr.push_back('{i, base + i});
    exp_dn.push_back('{e, dcyc});
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (exp_dn.size() != 0 && n < 300) begin tick(); n++; end
    chk(nm, exp_dn.size(), 0);
    repeat (3) tick();
  endtask

  initial begin
    int s, n;
    // reset held 3 cycles
    repeat (3) tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_pos_addr", int'(pos_addr), 0);
    chk("rst_dvalid", int'(dvalid), 0);
    chk("rst_focus_x", int'(cfx), 0);
    chk("rst_trans_x", int'(ctx), 0);
    chk("rst_we", int'(phase_we), 0);
    chk("rst_addr", int'(phase_addr), 0);
    chk("rst_data", int'(phase_data), 0);
    rst = 1'b0;
    tick();

    // nominal burst, plus a START during ISSUE that must be ignored
    s = cyc;
    push_op(s, 100, -200, 300, TN, 5, 0, -1);
    go(100, -200, 300);
    chk("busy_after_start", int'(busy), 1);
    chk("pos_addr_first", int'(pos_addr), 0);
    tick();
    go(1, 1, 1);
    wait_done("nominal_done_wait");
    chk("busy_after_done", int'(busy), 0);

    // six results for four beats; START lands with the final counted result
    model_en = 1'b0;
    s = cyc;
    push_op(s, 7, 8, 9, TN, 8'h40, 0, s + 13);
    go(7, 8, 9);
    repeat (7) tick();
    for (int i = 0; i < 6; i++) begin
      inj_v = 1'b1; inj_d = 8'(8'h40 + i);
      if (i == 3) begin start = 1'b1; fx = 18'(11); fy = 18'(12); fz = 18'(13); end
      tick();
      start = 1'b0;
    end
    inj_v = 1'b0;
    wait_done("extra_done_wait");

    // stale results while IDLE
    for (int i = 0; i < 3; i++) begin
      inj_v = 1'b1; inj_d = 8'(8'h70 + i);
      tick();
      chk("idle_we", int'(phase_we), 0);
    end
    inj_v = 1'b0;
    tick();
    chk("idle_we_tail", int'(phase_we), 0);
    chk("idle_busy", int'(busy), 0);

    // reset right after write index 1, then a clean full burst
    model_en = 1'b1;
    s = cyc;
    push_op(s, -5, 6, -7, TN, 5, 0, -1);
    go(-5, 6, -7);
    n = 0;
    while (!(phase_we && phase_addr == 8'd1) && n < 100) begin tick(); n++; end
    chk("midrst_wait_idx1", int'(n < 100), 1);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_we", int'(phase_we), 0);
    chk("midrst_focus_x", int'(cfx), 0);
    exp_dv.delete(); exp_wr.delete(); exp_dn.delete();
    tick();
    chk("midrst_busy_edge", int'(busy), 0);
    chk("midrst_addr_edge", int'(phase_addr), 0);
    rst = 1'b0;
    repeat (10) tick();
    s = cyc;
    push_op(s, 42, 43, 44, TN, 5, 0, -1);
    go(42, 43, 44);
    wait_done("post_rst_done_wait");

`ifdef FOCUS_SCHED_TIMEOUT_EN
    // only two results come back: DONE with ERR when the idle counter reads TMO
    model_lim = 2;
    s = cyc;
    push_op(s, 3, 4, 5, 2, 5, 1, s + 29 + TMO + 1);
    go(3, 4, 5);
    wait_done("timeout_done_wait");
    chk("err_sticky", int'(err), 1);
    model_lim = TN;
    s = cyc;
    push_op(s, 9, 9, 9, TN, 5, 0, -1);
    go(9, 9, 9);
    chk("err_cleared", int'(err), 0);
    wait_done("after_timeout_done_wait");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end
endmodule
